// File: rtl/nav_pkg.sv
// Shared codes for the line-navigation controller and the motor driver.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package nav_pkg;

    // Motor state codes; the motor driver decodes these same values.
    typedef enum logic [2:0] {
        MS_FRONT  = 3'd0,
        MS_STOP   = 3'd1,
        MS_RIGHT  = 3'd2,
        MS_LEFT   = 3'd3,
        MS_SLEFT  = 3'd4,
        MS_SRIGHT = 3'd5,
        MS_BACK   = 3'd6,
        MS_SPEED  = 3'd7
    } motor_t;

    // Route command opcodes.
    typedef enum logic [1:0] {
        OP_STRAIGHT = 2'd0,
        OP_LEFT     = 2'd1,
        OP_RIGHT    = 2'd2,
        OP_BACK     = 2'd3
    } op_t;

    // Controller FSM states; encodings 5..7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOLLOW = 3'd1,
        ST_CROSS  = 3'd2,
        ST_TURN   = 3'd3,
        ST_FAULT  = 3'd4
    } fsm_t;

    // Motor code driven while a turn command is executing at a node.
    function automatic motor_t turn_code(input op_t op);
        case (op)
            OP_LEFT:  return MS_LEFT;
            OP_RIGHT: return MS_RIGHT;
            OP_BACK:  return MS_BACK;
            default:  return MS_FRONT;
        endcase
    endfunction

endpackage

// File: rtl/line_debounce.sv
// Synchronises the async line sensors (2 flops) and debounces them into flt.
// Latency: flt follows a stable line_s change DEBOUNCE_CYC+2 clocks after it is first sampled.
// Backpressure: none; free-running filter.
// Ports: clk_50/rst_n clock and async active-low reset; line_s raw sensors
//        {left, centre, right}; flt filtered pattern.
module line_debounce
    import nav_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [2:0] line_s,
    output logic [2:0] flt
);

    localparam int             DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE_CYC);

    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      held;     // sync2 one cycle ago, to detect changes
    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] cnt_nxt;

    // cnt = number of consecutive cycles sync2 has held its current value;
    // the cycle in which sync2 takes a new value counts as the first.
    always_comb begin
        cnt_nxt = cnt;
        if (sync2 != held) begin
            cnt_nxt = DB_W'(1);
        end else if (cnt != DB_LIM) begin
            cnt_nxt = cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            held  <= 3'b000;
            cnt   <= '0;
            flt   <= 3'b000;
        end else begin
            sync1 <= line_s;
            sync2 <= sync1;
            held  <= sync2;
            cnt   <= cnt_nxt;
            if (cnt_nxt == DB_LIM) begin
                flt <= sync2;
            end
        end
    end

endmodule

// File: rtl/line_nav_ctrl.sv
// Line-following route controller: follows the line, counts nodes, executes one route command per node.
// Latency: state output is registered, 1 clock after a filtered-pattern change.
// Backpressure: cmd_ready is high only in IDLE; a new command waits until the previous one completes.
// Ports: clk_50/rst_n clock and async active-low reset; line_s raw sensors;
//        cmd_valid/cmd_op/cmd_ready route command handshake; state motor code;
//        done completion pulse; node_cnt saturating node count; fault sticky fault.
module line_nav_ctrl
    import nav_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50000,
    parameter int SPEED_CYC    = 25000000,
    parameter int TURN_MIN_CYC = 10000000,
    parameter int TURN_MAX_CYC = 100000000,
    parameter int LOST_CYC     = 5000000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [2:0] line_s,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic [2:0] state,
    output logic       done,
    output logic [7:0] node_cnt,
    output logic       fault
);

    localparam int               SPD_W    = $clog2(SPEED_CYC + 1);
    localparam int               LOST_W   = $clog2(LOST_CYC + 1);
    localparam int               TRN_W    = $clog2(TURN_MAX_CYC + 1);
    localparam logic [SPD_W-1:0]  SPD_LIM  = SPD_W'(SPEED_CYC);
    localparam logic [LOST_W-1:0] LOST_LIM = LOST_W'(LOST_CYC);
    localparam logic [TRN_W-1:0]  TMIN_LIM = TRN_W'(TURN_MIN_CYC);
    localparam logic [TRN_W-1:0]  TMAX_LIM = TRN_W'(TURN_MAX_CYC);

    logic [2:0]        flt;
    fsm_t              fsm_q,   fsm_d;
    motor_t            state_q, state_d;
    op_t               op_q,    op_d;
    logic              done_q,  done_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic [7:0]        node_q,  node_d;
    logic [SPD_W-1:0]  spd_q,   spd_d;
    logic [LOST_W-1:0] lost_q,  lost_d;
    logic [TRN_W-1:0]  turn_q,  turn_d;

    line_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .line_s (line_s),
        .flt    (flt)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        op_d    = op_q;
        done_d  = 1'b0;
        node_d  = node_q;
        // Counters clear whenever their qualifying condition is absent.
        spd_d   = '0;
        lost_d  = '0;
        turn_d  = '0;

        case (fsm_q)
            ST_IDLE: begin
                state_d = MS_STOP;
                if (cmd_valid && ready_q) begin
                    op_d  = op_t'(cmd_op);
                    fsm_d = ST_FOLLOW;
                end
            end
            ST_FOLLOW: begin
                case (flt)
                    3'b010: begin
                        spd_d   = (spd_q == SPD_LIM) ? spd_q : spd_q + SPD_W'(1);
                        state_d = (spd_d == SPD_LIM) ? MS_SPEED : MS_FRONT;
                    end
                    3'b110, 3'b100: state_d = MS_SLEFT;
                    3'b011, 3'b001: state_d = MS_SRIGHT;
                    3'b000: begin
                        // Line lost: hold the last correction while the timer runs.
                        lost_d = (lost_q == LOST_LIM) ? lost_q : lost_q + LOST_W'(1);
                        if (lost_d == LOST_LIM) begin
                            fsm_d   = ST_FAULT;
                            state_d = MS_STOP;
                        end
                    end
                    3'b111: begin
                        // FOLLOW is left on the same cycle, so each node counts once.
                        node_d = (node_q == 8'hFF) ? node_q : node_q + 8'd1;
                        if (op_q == OP_STRAIGHT) begin
                            fsm_d   = ST_CROSS;
                            state_d = MS_FRONT;
                        end else begin
                            fsm_d   = ST_TURN;
                            state_d = turn_code(op_q);
                        end
                    end
                    default: state_d = state_q;   // 101: ambiguous, keep course
                endcase
            end
            ST_CROSS: begin
                state_d = MS_FRONT;
                if (flt != 3'b111) begin
                    done_d  = 1'b1;
                    fsm_d   = ST_IDLE;
                    state_d = MS_STOP;
                end
            end
            ST_TURN: begin
                state_d = turn_code(op_q);
                // turn_d is the 1-based cycle index within the turn; the node
                // itself still shows centre=1, hence the minimum duration.
                turn_d  = (turn_q == TMAX_LIM) ? turn_q : turn_q + TRN_W'(1);
                if (turn_d >= TMIN_LIM && flt[1]) begin
                    done_d  = 1'b1;
                    fsm_d   = ST_IDLE;
                    state_d = MS_STOP;
                end else if (turn_d == TMAX_LIM) begin
                    fsm_d   = ST_FAULT;
                    state_d = MS_STOP;
                end
            end
            ST_FAULT: begin
                state_d = MS_STOP;
            end
            default: begin
                fsm_d   = ST_IDLE;
                state_d = MS_STOP;
            end
        endcase

        ready_d = (fsm_d == ST_IDLE);
        fault_d = (fsm_d == ST_FAULT);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= MS_STOP;
            op_q    <= OP_STRAIGHT;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            node_q  <= 8'd0;
            spd_q   <= '0;
            lost_q  <= '0;
            turn_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            op_q    <= op_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            node_q  <= node_d;
            spd_q   <= spd_d;
            lost_q  <= lost_d;
            turn_q  <= turn_d;
        end
    end

    assign cmd_ready = ready_q;
    assign state     = state_q;
    assign done      = done_q;
    assign node_cnt  = node_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_line_nav_ctrl.sv
// Scoreboard bench for line_nav_ctrl: stimulus pushes the expected output
// events, a monitor pops one per observed output change (or done pulse).
// Timing windows are enforced by bounded draining of the expectation queue.
module tb_line_nav_ctrl;

    localparam logic [2:0] M_FRONT  = 3'd0;
    localparam logic [2:0] M_STOP   = 3'd1;
    localparam logic [2:0] M_RIGHT  = 3'd2;
    localparam logic [2:0] M_LEFT   = 3'd3;
    localparam logic [2:0] M_SLEFT  = 3'd4;
    localparam logic [2:0] M_SRIGHT = 3'd5;
    localparam logic [2:0] M_SPEED  = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic       dn;
        logic [7:0] nc;
        logic       flt;
        logic       rdy;
    } ev_t;

    logic       clk_50    = 1'b0;
    logic       rst_n     = 1'b1;
    logic [2:0] line_s    = 3'b000;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'd0;
    logic       cmd_ready;
    logic [2:0] state;
    logic       done;
    logic [7:0] node_cnt;
    logic       fault;

    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    logic [7:0] exp_node = 8'd0;

    line_nav_ctrl #(
        .DEBOUNCE_CYC (4),
        .SPEED_CYC    (20),
        .TURN_MIN_CYC (10),
        .TURN_MAX_CYC (50),
        .LOST_CYC     (15)
    ) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .line_s    (line_s),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .state     (state),
        .done      (done),
        .node_cnt  (node_cnt),
        .fault     (fault)
    );

    always #10 clk_50 = ~clk_50;

    task automatic expect_ev(input logic [2:0] st, input logic dn, input logic [7:0] nc,
                             input logic fl, input logic rd);
        ev_t e;
        e.st = st; e.dn = dn; e.nc = nc; e.flt = fl; e.rdy = rd;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_50);
            #1;
        end
    endtask

    // Wait until every expected event has been observed; it must take between mn and mx cycles.
    task automatic drain(input int mn, input int mx, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < mx) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d events still pending after %0d cycles, required 0", nm, exp_q.size(), n);
            exp_q.delete();
        end else if (n < mn) begin
            failures++;
            $display("FAIL %s: response after %0d cycles, required at least %0d", nm, n, mn);
        end
    endtask

    task automatic check_now(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check_now("cmd_ready_wait", {7'd0, cmd_ready}, 8'd1);
        expect_ev(M_STOP, 1'b0, exp_node, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        drain(1, 1, "cmd_accept");
        cmd_valid = 1'b0;
    endtask

    // Assert reset mid-cycle, check outputs respond asynchronously, then release.
    task automatic do_reset(input logic [2:0] ls);
        rst_n     = 1'b0;
        line_s    = ls;
        cmd_valid = 1'b0;
        #1;
        check_now("rst_state", {5'd0, state}, {5'd0, M_STOP});
        check_now("rst_ready", {7'd0, cmd_ready}, 8'd0);
        check_now("rst_done", {7'd0, done}, 8'd0);
        check_now("rst_fault", {7'd0, fault}, 8'd0);
        check_now("rst_node", node_cnt, 8'd0);
        exp_node = 8'd0;
        tick(3);
        rst_n = 1'b1;
        expect_ev(M_STOP, 1'b0, 8'd0, 1'b0, 1'b1);
        drain(1, 1, "ready_after_reset");
    endtask

    // Monitor: one event per change of the outputs (done falling excluded) or per done pulse.
    initial begin
        ev_t cur;
        ev_t prev;
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk_50);
            cur = {state, done, node_cnt, fault, cmd_ready};
            if (!rst_n) begin
                prev = cur;
            end else begin
                if (cur.dn || {cur.st, cur.nc, cur.flt, cur.rdy} != {prev.st, prev.nc, prev.flt, prev.rdy}) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event: got st=%0d done=%0d node=%0d fault=%0d ready=%0d, required no event",
                                 cur.st, cur.dn, cur.nc, cur.flt, cur.rdy);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            failures++;
                            $display("FAIL event: got st=%0d done=%0d node=%0d fault=%0d ready=%0d, required st=%0d done=%0d node=%0d fault=%0d ready=%0d",
                                     cur.st, cur.dn, cur.nc, cur.flt, cur.rdy, e.st, e.dn, e.nc, e.flt, e.rdy);
                        end
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // Follow a centred line: front, then speed; a short dropout is filtered.
        do_reset(3'b010);
        issue_cmd(2'd1);
        expect_ev(M_FRONT, 1'b0, 8'd0, 1'b0, 1'b0);
        expect_ev(M_SPEED, 1'b0, 8'd0, 1'b0, 1'b0);
        drain(20, 35, "front_then_speed");
        line_s = 3'b000;
        tick(2);
        line_s = 3'b010;
        tick(12);
        check_now("glitch_keeps_speed", {5'd0, state}, {5'd0, M_SPEED});

        // Corrections: 7-cycle bound from raw sensor to motor code.
        line_s = 3'b110;
        expect_ev(M_SLEFT, 1'b0, 8'd0, 1'b0, 1'b0);
        drain(5, 7, "sleft_latency");
        line_s = 3'b011;
        expect_ev(M_SRIGHT, 1'b0, 8'd0, 1'b0, 1'b0);
        drain(5, 7, "sright_latency");

        // Left turn at a node; centre is still seen early and must be ignored.
        line_s   = 3'b111;
        exp_node = 8'd1;
        expect_ev(M_LEFT, 1'b0, 8'd1, 1'b0, 1'b0);
        drain(5, 7, "turn_entry");
        line_s = 3'b000;
        tick(5);
        line_s = 3'b010;
        expect_ev(M_STOP, 1'b1, 8'd1, 1'b0, 1'b1);
        drain(6, 8, "turn_done");
        tick(1);
        check_now("done_one_cycle", {7'd0, done}, 8'd0);

        // Right turn that never reacquires the line times out into FAULT.
        issue_cmd(2'd2);
        expect_ev(M_FRONT, 1'b0, 8'd1, 1'b0, 1'b0);
        drain(1, 3, "follow_front");
        line_s   = 3'b111;
        exp_node = 8'd2;
        expect_ev(M_RIGHT, 1'b0, 8'd2, 1'b0, 1'b0);
        drain(5, 7, "turn_right");
        line_s = 3'b000;
        expect_ev(M_STOP, 1'b0, 8'd2, 1'b1, 1'b0);
        drain(45, 52, "turn_timeout");
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        tick(10);
        cmd_valid = 1'b0;
        check_now("fault_sticky", {7'd0, fault}, 8'd1);
        check_now("fault_ready", {7'd0, cmd_ready}, 8'd0);

        // Line lost while following.
        do_reset(3'b000);
        issue_cmd(2'd0);
        expect_ev(M_STOP, 1'b0, 8'd0, 1'b1, 1'b0);
        drain(14, 16, "lost_fault");

        // 256 straight crossings: the node count saturates at 255.
        do_reset(3'b010);
        for (int i = 0; i < 256; i++) begin
            issue_cmd(2'd0);
            expect_ev(M_FRONT, 1'b0, exp_node, 1'b0, 1'b0);
            drain(1, 10, "cross_front");
            line_s = 3'b111;
            if (exp_node != 8'hFF) begin
                exp_node = exp_node + 8'd1;
                expect_ev(M_FRONT, 1'b0, exp_node, 1'b0, 1'b0);
            end
            tick(8);
            drain(0, 1, "cross_node");
            line_s = 3'b010;
            expect_ev(M_STOP, 1'b1, exp_node, 1'b0, 1'b1);
            drain(5, 8, "cross_done");
        end
        check_now("node_saturated", node_cnt, 8'd255);

        // Reset in the middle of a crossing: immediate reset values, no done afterwards.
        issue_cmd(2'd0);
        expect_ev(M_FRONT, 1'b0, 8'd255, 1'b0, 1'b0);
        drain(1, 3, "cross2_front");
        line_s = 3'b111;
        tick(8);
        do_reset(3'b000);
        tick(20);
        check_now("no_done_after_reset", {7'd0, done}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_nav_ctrl.md
LINE_NAV_CTRL -- requirements
Module: line_nav_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 50000: consecutive stable cycles before a filtered sensor pattern updates (1 ms at 50 MHz).
REQ-002 Parameter SPEED_CYC, default 25000000: cycles of continuous centred line before the speed code is issued.
REQ-003 Parameter TURN_MIN_CYC, default 10000000: minimum turn duration before line reacquisition is honoured.
REQ-004 Parameter TURN_MAX_CYC, default 100000000: turn timeout.
REQ-005 Parameter LOST_CYC, default 5000000: tolerated line-lost duration.
REQ-006 Port clk_50, input, 1: single system clock (50 MHz).
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port line_s, input, 3: asynchronous line sensors; [2] left, [1] centre, [0] right; 1 = on line.
REQ-009 Port cmd_valid, input, 1: route command offered.
REQ-010 Port cmd_op, input, 2: 0 straight, 1 left, 2 right, 3 back.
REQ-011 Port cmd_ready, output, 1: command can be accepted.
REQ-012 Port state, output, 3: motor state code to the motor driver; front=0, stop=1, right=2, left=3, sleft=4, sright=5, back=6, speed=7.
REQ-013 Port done, output, 1: one-cycle pulse when a command completes.
REQ-014 Port node_cnt, output, 8: count of nodes passed, saturating at 255.
REQ-015 Port fault, output, 1: sticky fault flag.

Function
REQ-016 line_s SHALL pass a 2-flop synchroniser, then a debouncer; the filtered pattern (flt) updates only after the synchronised value has been unchanged for DEBOUNCE_CYC consecutive cycles.
REQ-017 FSM states: IDLE, FOLLOW, CROSS, TURN, FAULT.
REQ-018 IDLE: state=stop, cmd_ready=1. cmd_valid&cmd_ready latches cmd_op and enters FOLLOW on the next cycle. cmd_ready is 0 in every other state.
REQ-019 FOLLOW: flt 010 -> front, or speed once 010 has been held SPEED_CYC cycles (the hold counter clears on any other pattern). 110/100 -> sleft. 011/001 -> sright. 101 -> keep the previous code.
REQ-020 FOLLOW, flt 000: keep the last correction code; if 000 persists LOST_CYC cycles -> FAULT.
REQ-021 FOLLOW, flt 111 (node): node_cnt increments once per node, saturating at 255. op straight -> CROSS. op left/right/back -> TURN.
REQ-022 CROSS: state=front until flt leaves 111, then done pulse and IDLE.
REQ-023 TURN: state=left, right or back per op. After at least TURN_MIN_CYC cycles, flt[1]=1 -> done pulse and IDLE. Reaching TURN_MAX_CYC without that -> FAULT.
REQ-024 FAULT: state=stop, fault=1, cmd_ready=0; exited only by reset.
REQ-025 The state output SHALL be registered; latency from a flt change to a state change is exactly 1 cycle.
REQ-026 The state output SHALL only take values from REQ-012; an undefined FSM encoding recovers to IDLE.
REQ-027 Every counter SHALL saturate or clear and never wrap; each counter is sized to its parameter.

Reset
REQ-028 Asserting rst_n (low) SHALL asynchronously force: state=stop, cmd_ready=0, done=0, fault=0, node_cnt=0, FSM=IDLE, all counters 0, synchroniser and flt cleared to 000.
REQ-029 cmd_ready SHALL assert on the first clock after rst_n deasserts; reset mid-turn aborts the turn without a done pulse.

Structure
REQ-030 A shared package nav_pkg SHALL hold the motor state codes, the cmd_op codes and the FSM state enumeration; the motor driver uses the same state codes.
REQ-031 A single sub-module, line_debounce, SHALL hold the synchroniser and debouncer (parameter DEBOUNCE_CYC).

Verification (DEBOUNCE_CYC=4, SPEED_CYC=20, TURN_MIN_CYC=10, TURN_MAX_CYC=50, LOST_CYC=15)
REQ-032 Reset, then cmd op=1 accepted, line_s=010 for 30 cycles -> state front, then speed after 20 stable cycles; a 2-cycle 000 glitch leaves state unchanged.
REQ-033 FOLLOW, line_s=110 -> sleft within 2+4+1 cycles; line_s=011 -> sright.
REQ-034 line_s=111 with op=1 -> node_cnt=1, state=left; centre seen at cycle 5 is ignored; centre seen at cycle 12 -> done pulse, state=stop, cmd_ready=1.
REQ-035 TURN with line_s=000 for 50 cycles -> fault=1, state=stop, cmd_valid ignored until reset.
REQ-036 FOLLOW with line_s=000 for 15 cycles -> FAULT. Separately, 256 straight crossings -> node_cnt stays 255.
REQ-037 rst_n pulsed low mid-CROSS -> all outputs at reset values immediately, with no done pulse.
